// File: rtl/nf10_axis_capture_buffer.sv
// AXI4-Stream tap that records packet-aligned captures into a BRAM ring
// and replays them on an AXIS master port on request.
module nf10_axis_capture_buffer #(
    parameter int         C_S_AXIS_DATA_WIDTH  = 256,
    parameter int         C_S_AXIS_TUSER_WIDTH = 128,
    parameter int         C_DEPTH              = 512,
    parameter int         C_WRAP               = 0,
    parameter int         C_READY_MODE         = 0,
    parameter logic [7:0] C_THROTTLE_PATTERN   = 8'b1110_1110,
    localparam int        AW = $clog2(C_DEPTH),
    localparam int        SW = C_S_AXIS_DATA_WIDTH / 8
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [SW-1:0]                   s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    input  logic                            arm,
    input  logic                            stop,
    input  logic                            drain,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]  m_axis_tdata,
    output logic [SW-1:0]                   m_axis_tstrb,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic [2:0]                      state,
    output logic [31:0]                     pkt_count,
    output logic [31:0]                     beat_count,
    output logic [AW:0]                     fill_level,
    output logic                            overflow
);

    localparam int         MW        = 1 + C_S_AXIS_TUSER_WIDTH + SW + C_S_AXIS_DATA_WIDTH;
    localparam logic [AW:0] LAST_FREE = (AW + 1)'(C_DEPTH - 1);
    localparam logic [AW:0] ONE_WORD  = (AW + 1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DONE    = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fetch_ptr_q, fetch_ptr_d;
    logic [31:0]   pkt_count_q, pkt_count_d, beat_count_q, beat_count_d;
    logic          overflow_q, overflow_d, stop_pend_q, stop_pend_d;
    logic          skip_q, skip_d, rvalid_q, rvalid_d, in_pkt_q;
    logic          accept, wr_en, rd_en, consume, force_last, stop_seen, arm_clear;
    logic [AW:0]   fill;
    logic [MW-1:0] mem [C_DEPTH];
    logic [MW-1:0] rdata_q;
    logic [MW-1:0] wdata;

    generate
        if (C_READY_MODE == 0) begin : g_ready_const
            logic ready_q;
            always_ff @(posedge aclk) begin
                if (!aresetn) ready_q <= 1'b0;
                else          ready_q <= 1'b1;
            end
            assign s_axis_tready = ready_q;
        end else begin : g_ready_throttle
            logic [7:0] pattern_q;
            always_ff @(posedge aclk) begin
                if (!aresetn) pattern_q <= C_THROTTLE_PATTERN;
                else          pattern_q <= {pattern_q[0], pattern_q[7:1]};
            end
            assign s_axis_tready = pattern_q[0];
        end
    endgenerate

    assign accept = s_axis_tvalid & s_axis_tready;
    assign fill   = wr_ptr_q - rd_ptr_q;
    assign wdata  = {s_axis_tlast | force_last, s_axis_tuser, s_axis_tstrb, s_axis_tdata};

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fetch_ptr_d  = fetch_ptr_q;
        pkt_count_d  = pkt_count_q;
        beat_count_d = beat_count_q;
        overflow_d   = overflow_q;
        stop_pend_d  = stop_pend_q;
        skip_d       = skip_q;
        rvalid_d     = rvalid_q;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        consume      = 1'b0;
        force_last   = 1'b0;
        stop_seen    = 1'b0;
        arm_clear    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d   = ST_ARMED;
                    arm_clear = 1'b1;
                end
            end
            ST_ARMED: begin
                if (stop) begin
                    state_d = ST_DONE;
                end else if (accept && !in_pkt_q) begin
                    wr_en   = 1'b1;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                stop_seen   = stop | stop_pend_q;
                stop_pend_d = stop_seen;
                // Between packets a pending stop ends capture before the next packet starts.
                if (stop_seen && !in_pkt_q) begin
                    state_d = ST_DONE;
                end else if (accept) begin
                    wr_en = 1'b1;
                    if (C_WRAP != 0) begin
                        if (fill[AW]) begin
                            rd_ptr_d   = rd_ptr_q + 1'b1;
                            overflow_d = 1'b1;
                        end
                    end else if (fill == LAST_FREE) begin
                        state_d    = ST_DONE;
                        force_last = ~s_axis_tlast;
                        overflow_d = overflow_q | ~s_axis_tlast;
                    end
                    if (s_axis_tlast && stop_seen) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (arm) begin
                    state_d   = ST_ARMED;
                    arm_clear = 1'b1;
                end else if (drain) begin
                    state_d     = ST_DRAIN;
                    fetch_ptr_d = rd_ptr_q;
                    skip_d      = (C_WRAP != 0) && overflow_q;
                end
            end
            ST_DRAIN: begin
                // Skipped words are consumed internally without ever raising tvalid.
                consume = rvalid_q && (skip_q || m_axis_tready);
                rd_en   = (fetch_ptr_q != wr_ptr_q) && (!rvalid_q || consume);
                if (consume) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if (skip_q && rdata_q[MW-1]) skip_d = 1'b0;
                end
                if (rd_en) begin
                    fetch_ptr_d = fetch_ptr_q + 1'b1;
                    rvalid_d    = 1'b1;
                end else if (consume) begin
                    rvalid_d = 1'b0;
                end
                if (fill == '0 || (consume && fill == ONE_WORD)) begin
                    state_d = ST_IDLE;
                    skip_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (wr_en) begin
            wr_ptr_d     = wr_ptr_q + 1'b1;
            beat_count_d = beat_count_q + 32'd1;
            if (s_axis_tlast) pkt_count_d = pkt_count_q + 32'd1;
        end
        if (arm_clear) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            pkt_count_d  = '0;
            beat_count_d = '0;
            overflow_d   = 1'b0;
            stop_pend_d  = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fetch_ptr_q  <= '0;
            pkt_count_q  <= '0;
            beat_count_q <= '0;
            overflow_q   <= 1'b0;
            stop_pend_q  <= 1'b0;
            skip_q       <= 1'b0;
            rvalid_q     <= 1'b0;
            in_pkt_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fetch_ptr_q  <= fetch_ptr_d;
            pkt_count_q  <= pkt_count_d;
            beat_count_q <= beat_count_d;
            overflow_q   <= overflow_d;
            stop_pend_q  <= stop_pend_d;
            skip_q       <= skip_d;
            rvalid_q     <= rvalid_d;
            if (accept) in_pkt_q <= ~s_axis_tlast;
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wdata;
    end

    // The BRAM output register doubles as the replay output stage.
    always_ff @(posedge aclk) begin
        if (!aresetn)   rdata_q <= '0;
        else if (rd_en) rdata_q <= mem[fetch_ptr_q[AW-1:0]];
    end

    assign m_axis_tdata  = rdata_q[C_S_AXIS_DATA_WIDTH-1:0];
    assign m_axis_tstrb  = rdata_q[C_S_AXIS_DATA_WIDTH +: SW];
    assign m_axis_tuser  = rdata_q[C_S_AXIS_DATA_WIDTH+SW +: C_S_AXIS_TUSER_WIDTH];
    assign m_axis_tlast  = rdata_q[MW-1];
    assign m_axis_tvalid = rvalid_q & ~skip_q;
    assign state         = state_q;
    assign pkt_count     = pkt_count_q;
    assign beat_count    = beat_count_q;
    assign fill_level    = fill;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_nf10_axis_capture_buffer.sv
// Directed bench: three capture-buffer configurations share one stimulus bus,
// selected by sel (0: depth 16 stop-on-full, 1: depth 8 throttled, 2: depth 8 wrap).
module tb_nf10_axis_capture_buffer;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] s_tdata;
    logic [3:0]  s_tstrb;
    logic [7:0]  s_tuser;
    logic        s_tvalid, s_tlast, arm_s, stop_s, drain_s, m_tready, arm_on_beat;
    int          sel;
    int          n_checks = 0;
    int          n_pass   = 0;

    logic [2:0]  v_i, a_i, p_i, d_i;
    logic        o_sready [3];
    logic        o_mvalid [3];
    logic        o_mlast  [3];
    logic        o_ovf    [3];
    logic [31:0] o_mdata  [3];
    logic [31:0] o_pkt    [3];
    logic [31:0] o_beat   [3];
    logic [3:0]  o_mstrb  [3];
    logic [7:0]  o_muser  [3];
    logic [2:0]  o_state  [3];
    logic [4:0]  fill_b;
    logic [3:0]  fill_f, fill_w;

    logic        sready, mvalid, mlast, ovf;
    logic [31:0] mdata, pkt, beat;
    logic [3:0]  mstrb;
    logic [7:0]  muser;
    logic [2:0]  st;
    logic [4:0]  fill;

    logic [63:0] exp_q [$];
    logic [63:0] got_q [$];

    always #5 aclk = ~aclk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_gate
        assign v_i[gi] = s_tvalid && (sel == gi);
        assign a_i[gi] = arm_s    && (sel == gi);
        assign p_i[gi] = stop_s   && (sel == gi);
        assign d_i[gi] = drain_s  && (sel == gi);
    end

    nf10_axis_capture_buffer #(
        .C_S_AXIS_DATA_WIDTH(32), .C_S_AXIS_TUSER_WIDTH(8), .C_DEPTH(16),
        .C_WRAP(0), .C_READY_MODE(0), .C_THROTTLE_PATTERN(8'b1110_1110)
    ) u_basic (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(v_i[0]), .s_axis_tready(o_sready[0]), .s_axis_tlast(s_tlast),
        .arm(a_i[0]), .stop(p_i[0]), .drain(d_i[0]),
        .m_axis_tdata(o_mdata[0]), .m_axis_tstrb(o_mstrb[0]), .m_axis_tuser(o_muser[0]),
        .m_axis_tvalid(o_mvalid[0]), .m_axis_tready(m_tready), .m_axis_tlast(o_mlast[0]),
        .state(o_state[0]), .pkt_count(o_pkt[0]), .beat_count(o_beat[0]),
        .fill_level(fill_b), .overflow(o_ovf[0])
    );

    nf10_axis_capture_buffer #(
        .C_S_AXIS_DATA_WIDTH(32), .C_S_AXIS_TUSER_WIDTH(8), .C_DEPTH(8),
        .C_WRAP(0), .C_READY_MODE(1), .C_THROTTLE_PATTERN(8'b1110_1110)
    ) u_full (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(v_i[1]), .s_axis_tready(o_sready[1]), .s_axis_tlast(s_tlast),
        .arm(a_i[1]), .stop(p_i[1]), .drain(d_i[1]),
        .m_axis_tdata(o_mdata[1]), .m_axis_tstrb(o_mstrb[1]), .m_axis_tuser(o_muser[1]),
        .m_axis_tvalid(o_mvalid[1]), .m_axis_tready(m_tready), .m_axis_tlast(o_mlast[1]),
        .state(o_state[1]), .pkt_count(o_pkt[1]), .beat_count(o_beat[1]),
        .fill_level(fill_f), .overflow(o_ovf[1])
    );

    nf10_axis_capture_buffer #(
        .C_S_AXIS_DATA_WIDTH(32), .C_S_AXIS_TUSER_WIDTH(8), .C_DEPTH(8),
        .C_WRAP(1), .C_READY_MODE(0), .C_THROTTLE_PATTERN(8'b1110_1110)
    ) u_wrap (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(v_i[2]), .s_axis_tready(o_sready[2]), .s_axis_tlast(s_tlast),
        .arm(a_i[2]), .stop(p_i[2]), .drain(d_i[2]),
        .m_axis_tdata(o_mdata[2]), .m_axis_tstrb(o_mstrb[2]), .m_axis_tuser(o_muser[2]),
        .m_axis_tvalid(o_mvalid[2]), .m_axis_tready(m_tready), .m_axis_tlast(o_mlast[2]),
        .state(o_state[2]), .pkt_count(o_pkt[2]), .beat_count(o_beat[2]),
        .fill_level(fill_w), .overflow(o_ovf[2])
    );

    always_comb begin
        sready = o_sready[sel];
        mvalid = o_mvalid[sel];
        mlast  = o_mlast[sel];
        ovf    = o_ovf[sel];
        mdata  = o_mdata[sel];
        pkt    = o_pkt[sel];
        beat   = o_beat[sel];
        mstrb  = o_mstrb[sel];
        muser  = o_muser[sel];
        st     = o_state[sel];
        fill   = (sel == 0) ? fill_b : {1'b0, ((sel == 1) ? fill_f : fill_w)};
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] beat_data(input int p, input int i);
        return 32'hBE00_0000 | 32'(p << 8) | 32'(i);
    endfunction

    function automatic logic [63:0] mk_word(input logic [31:0] d, input logic last);
        return {19'd0, last, d[7:0] ^ 8'h5A, ~d[3:0], d};
    endfunction

    task automatic send_beat(input logic [31:0] d, input logic last);
        int n;
        n = 0;
        @(negedge aclk);
        s_tdata  = d;
        s_tstrb  = ~d[3:0];
        s_tuser  = d[7:0] ^ 8'h5A;
        s_tlast  = last;
        s_tvalid = 1'b1;
        arm_s    = arm_on_beat;
        while (!sready && n < 32) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 32) check_eq("send_timeout", 64'(0), 64'(1));
        @(posedge aclk);
        #1;
        s_tvalid    = 1'b0;
        s_tlast     = 1'b0;
        arm_s       = 1'b0;
        arm_on_beat = 1'b0;
    endtask

    task automatic send_pkt(input int p, input int len);
        for (int i = 0; i < len; i++) send_beat(beat_data(p, i), i == len - 1);
    endtask

    task automatic push_exp(input int p, input int from, input int upto, input int last_idx);
        for (int i = from; i <= upto; i++) exp_q.push_back(mk_word(beat_data(p, i), i == last_idx));
    endtask

    task automatic pulse(input logic a, input logic s, input logic d);
        @(negedge aclk);
        arm_s = a; stop_s = s; drain_s = d;
        @(negedge aclk);
        arm_s = 1'b0; stop_s = 1'b0; drain_s = 1'b0;
    endtask

    task automatic drain_collect(input string name, input bit rnd, input bit lat);
        int          cyc, hold_err, n;
        bit          hold_pend;
        logic [63:0] held, cur;
        got_q.delete();
        cyc = 0; hold_err = 0; hold_pend = 0; held = '0;
        m_tready = 1'b0;
        @(negedge aclk);
        drain_s = 1'b1;
        @(negedge aclk);
        drain_s = 1'b0;
        if (lat) check_eq({name, "_valid_c1"}, 64'(mvalid), 64'(0));
        while (cyc < 400) begin
            @(negedge aclk);
            cyc++;
            cur = {19'd0, mlast, muser, mstrb, mdata};
            if (lat && cyc == 1) check_eq({name, "_valid_c2"}, 64'(mvalid), 64'(1));
            if (hold_pend && (!mvalid || cur !== held)) hold_err++;
            hold_pend = 0;
            m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mvalid) begin
                if (m_tready) begin
                    got_q.push_back(cur);
                    $display("replay %s[%0d] data=%08h strb=%h user=%02h last=%0b",
                             name, got_q.size() - 1, mdata, mstrb, muser, mlast);
                end else begin
                    hold_pend = 1;
                    held      = cur;
                end
            end
            if (st == 3'd0 && !mvalid) break;
        end
        m_tready = 1'b0;
        check_eq({name, "_end_idle"}, 64'(st), 64'(0));
        check_eq({name, "_hold_errs"}, 64'(hold_err), 64'(0));
        check_eq({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_eq($sformatf("%s_beat%0d", name, i), got_q[i], exp_q[i]);
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        int         cnt;
        aresetn = 1'b0; sel = 0;
        s_tdata = '0; s_tstrb = '0; s_tuser = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        arm_s = 1'b0; stop_s = 1'b0; drain_s = 1'b0; m_tready = 1'b0; arm_on_beat = 1'b0;
        repeat (3) @(negedge aclk);
        check_eq("rst_sready_const", 64'(o_sready[0]), 64'(0));
        check_eq("rst_sready_thr", 64'(o_sready[1]), 64'(0));
        aresetn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pat[i] = o_sready[1];
            @(negedge aclk);
        end
        check_eq("throttle_pattern", 64'(pat), 64'h0EE);
        check_eq("sready_const", 64'(o_sready[0]), 64'(1));
        check_eq("rst_state", 64'(st), 64'(0));
        check_eq("rst_mvalid", 64'(mvalid), 64'(0));
        check_eq("rst_counts", {pkt, beat}, 64'(0));
        check_eq("rst_fill_ovf", 64'({fill, ovf}), 64'(0));

        // Basic capture: 4 + 1 + 7 beats.
        sel = 0;
        pulse(1'b1, 1'b0, 1'b0);
        check_eq("basic_armed", 64'(st), 64'(1));
        send_pkt(1, 4); send_pkt(2, 1); send_pkt(3, 7);
        pulse(1'b0, 1'b1, 1'b0);
        check_eq("basic_state", 64'(st), 64'(3));
        check_eq("basic_pkt", 64'(pkt), 64'(3));
        check_eq("basic_beat", 64'(beat), 64'(12));
        check_eq("basic_fill", 64'(fill), 64'(12));
        check_eq("basic_ovf", 64'(ovf), 64'(0));
        push_exp(1, 0, 3, 3); push_exp(2, 0, 0, 0); push_exp(3, 0, 6, 6);
        drain_collect("basic", 1'b0, 1'b1);
        check_eq("basic_fill_after", 64'(fill), 64'(0));

        // Arm in the middle of a packet: that packet is discarded.
        send_beat(beat_data(10, 0), 1'b0);
        arm_on_beat = 1'b1;
        send_beat(beat_data(10, 1), 1'b0);
        send_beat(beat_data(10, 2), 1'b0);
        send_beat(beat_data(10, 3), 1'b0);
        send_beat(beat_data(10, 4), 1'b1);
        send_pkt(11, 3);
        pulse(1'b0, 1'b1, 1'b0);
        check_eq("midarm_fill", 64'(fill), 64'(3));
        check_eq("midarm_pkt", 64'(pkt), 64'(1));
        check_eq("midarm_beat", 64'(beat), 64'(3));
        push_exp(11, 0, 2, 2);
        drain_collect("midarm", 1'b1, 1'b0);

        // Reset after two replay beats, then a fresh capture.
        pulse(1'b1, 1'b0, 1'b0);
        send_pkt(20, 5);
        pulse(1'b0, 1'b1, 1'b0);
        @(negedge aclk);
        drain_s = 1'b1;
        @(negedge aclk);
        drain_s = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20 && cnt < 2; i++) begin
            @(negedge aclk);
            m_tready = 1'b1;
            if (mvalid) cnt++;
        end
        check_eq("rstdrain_two_beats", 64'(cnt), 64'(2));
        @(negedge aclk);
        m_tready = 1'b0;
        aresetn  = 1'b0;
        @(negedge aclk);
        aresetn  = 1'b1;
        check_eq("rstdrain_mvalid", 64'(mvalid), 64'(0));
        check_eq("rstdrain_state", 64'(st), 64'(0));
        check_eq("rstdrain_counts", {pkt, beat}, 64'(0));
        check_eq("rstdrain_fill", 64'(fill), 64'(0));
        pulse(1'b1, 1'b0, 1'b0);
        send_pkt(21, 2);
        pulse(1'b0, 1'b1, 1'b0);
        check_eq("recap_state", 64'(st), 64'(3));
        check_eq("recap_pkt", 64'(pkt), 64'(1));
        check_eq("recap_fill", 64'(fill), 64'(2));
        push_exp(21, 0, 1, 1);
        drain_collect("recap", 1'b1, 1'b0);

        // Stop-on-full with a throttled tap: 10-beat packet into 8 words.
        sel = 1;
        pulse(1'b1, 1'b0, 1'b0);
        send_pkt(30, 10);
        check_eq("full_state", 64'(st), 64'(3));
        check_eq("full_ovf", 64'(ovf), 64'(1));
        check_eq("full_fill", 64'(fill), 64'(8));
        check_eq("full_beat", 64'(beat), 64'(8));
        check_eq("full_pkt", 64'(pkt), 64'(0));
        push_exp(30, 0, 7, 7);
        drain_collect("full", 1'b1, 1'b0);

        // Throttled capture with random replay backpressure.
        pulse(1'b1, 1'b0, 1'b0);
        send_pkt(40, 3); send_pkt(41, 2);
        pulse(1'b0, 1'b1, 1'b0);
        check_eq("thr_pkt", 64'(pkt), 64'(2));
        check_eq("thr_ovf", 64'(ovf), 64'(0));
        push_exp(40, 0, 2, 2); push_exp(41, 0, 1, 1);
        drain_collect("thr", 1'b1, 1'b0);

        // Wrap mode: 3 + 3 + 4 beats into 8 words.
        sel = 2;
        pulse(1'b1, 1'b0, 1'b0);
        send_pkt(50, 3); send_pkt(51, 3); send_pkt(52, 4);
        pulse(1'b0, 1'b1, 1'b0);
        check_eq("wrap_fill", 64'(fill), 64'(8));
        check_eq("wrap_ovf", 64'(ovf), 64'(1));
        check_eq("wrap_pkt", 64'(pkt), 64'(3));
        check_eq("wrap_beat", 64'(beat), 64'(10));
        push_exp(51, 0, 2, 2); push_exp(52, 0, 3, 3);
        drain_collect("wrap", 1'b1, 1'b0);

        // arm+stop together in IDLE arms; an empty drain returns to IDLE.
        pulse(1'b1, 1'b1, 1'b0);
        check_eq("armstop_state", 64'(st), 64'(1));
        pulse(1'b0, 1'b1, 1'b0);
        check_eq("armed_stop_state", 64'(st), 64'(3));
        pulse(1'b0, 1'b0, 1'b1);
        @(negedge aclk);
        check_eq("empty_drain_state", 64'(st), 64'(0));
        check_eq("empty_drain_mvalid", 64'(mvalid), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nf10_axis_capture_buffer.md
Name: nf10_axis_capture_buffer

Overview:
- Parametrised, synthesizable successor to the simulation-only AXI4-Stream recorder.
- Taps an AXIS stream, such as an output-queue port, and stores accepted beats (tdata/tstrb/tuser/tlast) in an on-chip BRAM ring.
- Capture is packet-aligned arm/stop, with selectable wrap or stop-on-full.
- Stored beats are replayed on an AXIS master for readback by host logic or a bench.

Parameters:
- C_S_AXIS_DATA_WIDTH, 256, tdata width; multiple of 8. tstrb width = C_S_AXIS_DATA_WIDTH/8.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width.
- C_DEPTH, 512, stored beats; power of two, ≥4. AW = log2(C_DEPTH).
- C_WRAP, 0: 0 = stop on full; 1 = overwrite oldest.
- C_READY_MODE, 0: 0 = s_axis_tready constant 1 out of reset; 1 = throttled by pattern.
- C_THROTTLE_PATTERN, 8'b1110_1110: per-cycle tready pattern, LSB first, rotated right every cycle.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  monitored data
- s_axis_tstrb  in  C_S_AXIS_DATA_WIDTH/8  byte strobes
- s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  sideband
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accept
- s_axis_tlast  in  1  end of packet
- arm  in  1  pulse: start capture
- stop  in  1  pulse: end capture at the next packet boundary
- drain  in  1  pulse: replay the buffer
- m_axis_tdata  out  C_S_AXIS_DATA_WIDTH  replay data
- m_axis_tstrb  out  C_S_AXIS_DATA_WIDTH/8  replay strobes
- m_axis_tuser  out  C_S_AXIS_TUSER_WIDTH  replay sideband
- m_axis_tvalid  out  1  replay valid
- m_axis_tready  in  1  replay accept
- m_axis_tlast  out  1  replay end of packet
- state  out  3  current FSM state encoding
- pkt_count  out  32  packets stored since arm
- beat_count  out  32  beats stored since arm
- fill_level  out  AW+1  occupied words
- overflow  out  1  sticky; capture cut short by full buffer

Behaviour:
- Reset (aresetn=0 at an aclk edge):
  - FSM returns to IDLE and pointers clear.
  - All outputs are 0, including s_axis_tready and m_axis_tvalid.
  - A reset mid-capture or mid-drain aborts it; the BRAM contents are don't-care.
- Accept condition: beat accepted = s_axis_tvalid & s_axis_tready.
- s_axis_tready is independent of FSM state, so the tap never stalls differently when idle:
  - C_READY_MODE=0: tready = 1.
  - C_READY_MODE=1: tready = pattern[0]; the pattern resets to C_THROTTLE_PATTERN.
- SOP tracking: an internal in_pkt flag sets on an accepted beat with tlast=0 and clears on an accepted beat with tlast=1.
- State IDLE (0):
  - arm → ARMED.
  - stop and drain are ignored.
- State ARMED (1):
  - On the first accepted beat with in_pkt=0: write it and go to CAPTURE. If that beat has tlast=1, the packet is stored complete.
  - Beats accepted while in_pkt=1 are discarded.
  - stop → DONE with nothing stored.
- State CAPTURE (2):
  - Every accepted beat is written at wr_ptr; wr_ptr increments modulo C_DEPTH; beat_count increments.
  - An accepted tlast increments pkt_count.
  - stop is latched. The transition to DONE happens on the cycle after the accepted tlast, or immediately if in_pkt=0 when stop is seen.
- Full handling, C_WRAP=0: when the write filling the last free word is not tlast:
  - the stored tlast bit is forced to 1;
  - overflow sets;
  - FSM → DONE.
  - If that write is tlast, the FSM → DONE without setting overflow.
- Full handling, C_WRAP=1:
  - A write when full advances rd_ptr (oldest lost) and sets overflow.
  - fill_level saturates at C_DEPTH.
- State DONE (3):
  - Capture is frozen; drain → DRAIN.
  - arm → ARMED; this clears counters, pointers and overflow.
- State DRAIN (4):
  - Reads run from rd_ptr. BRAM read latency is 1 cycle; the output register holds data under m_axis_tready=0.
  - m_axis_tvalid first asserts 2 cycles after the drain pulse.
  - Each m_axis handshake decrements fill_level.
  - With C_WRAP=1 and overflow=1, leading words up to and including the first stored tlast are skipped without output, so replay starts on a packet boundary.
  - When fill_level reaches 0 after the final handshake: FSM → IDLE and m_axis_tvalid → 0 on the next cycle.
- Simultaneous events:
  - arm and stop in the same cycle in IDLE → ARMED; stop is dropped.
  - A drain pulse outside DONE is ignored.
  - A capture write and a replay read never coincide.
- Counters:
  - pkt_count and beat_count wrap at 2^32.
  - fill_level = wr_ptr - rd_ptr, computed with an extra MSB.

Test Plan:
- Basic capture: C_READY_MODE=0. Arm, send 3 packets of 4, 1 and 7 beats, then stop → DONE, pkt_count=3, beat_count=12, fill_level=12, overflow=0. Drain with m_axis_tready=1 → 12 beats byte-identical, tlast on beats 4, 5 and 12.
- Mid-packet arm: arm during beat 2 of a 5-beat packet, then send a 3-beat packet → beats of the first packet are discarded; fill_level=3; pkt_count=1.
- Stop on full: C_DEPTH=8, C_WRAP=0. Send a 10-beat packet → 8 stored, beat 8 replays with tlast=1, overflow=1, FSM in DONE.
- Wrap: C_DEPTH=8, C_WRAP=1. Send packets of 3, 3 and 4 beats → fill_level=8, overflow=1. Replay skips 1 word (the 2 oldest beats of packet 1 were overwritten) and outputs 7 beats, i.e. packets 2 and 3.
- Backpressure and throttle: C_READY_MODE=1 with default pattern, and random m_axis_tready → s_axis_tready low on cycles 4 and 8 modulo 8. Replay data holds stable while m_axis_tready=0; no beats are lost or duplicated.
- Reset mid-drain: assert aresetn=0 after 2 replay beats → the next cycle shows m_axis_tvalid=0, state=0 (IDLE) and counters 0; a subsequent arm/capture works normally.
